// File: rtl/filt_mac_pkg.sv
// Shared types and elaboration helpers for the MAC FIR sequencer.
package filt_mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        DONE
    } seq_state_t;

    // Rounds up so the middle tap of an odd symmetric filter gets its own MAC cycle.
    function automatic int unsigned div2(input int unsigned n);
        return (n + 1) / 2;
    endfunction

    function automatic int unsigned addr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/filt_mac_seq_if.sv
// Sample handshake and datapath control bundle between the FIR sequencer and its datapath.
interface filt_mac_seq_if #(
    parameter int unsigned AW    = 5,
    parameter int unsigned CNT_W = 8
);
    logic             i_ena;
    logic             i_valid;
    logic             o_ready;
    logic             o_wr_en;
    logic [AW-1:0]    o_wr_addr;
    logic [AW-1:0]    o_rd_addr_a;
    logic [AW-1:0]    o_rd_addr_b;
    logic [AW-1:0]    o_coeff_addr;
    logic             o_mid;
    logic             o_acc_clr;
    logic             o_acc_en;
    logic             o_done;
    logic [CNT_W-1:0] o_drop_cnt;

    modport master (
        input  i_ena, i_valid,
        output o_ready, o_wr_en, o_wr_addr, o_rd_addr_a, o_rd_addr_b, o_coeff_addr,
               o_mid, o_acc_clr, o_acc_en, o_done, o_drop_cnt
    );

    modport slave (
        output i_ena, i_valid,
        input  o_ready, o_wr_en, o_wr_addr, o_rd_addr_a, o_rd_addr_b, o_coeff_addr,
               o_mid, o_acc_clr, o_acc_en, o_done, o_drop_cnt
    );
endinterface

// File: rtl/filt_mac_seq_addr.sv
// Modulo-N address step: result = (base +/- step) mod N, no power-of-2 assumption on N.
module filt_mac_seq_addr #(
    parameter int unsigned gp_coeff_length = 17,
    parameter int unsigned gp_aw           = 5
) (
    input  logic [gp_aw-1:0] base,
    input  logic [gp_aw-1:0] step,
    input  logic             sub,
    output logic [gp_aw-1:0] result
);
    localparam logic [gp_aw:0] N_EXT = (gp_aw + 1)'(gp_coeff_length);

    logic [gp_aw:0] sum, diff, sum_wrap, diff_wrap;

    always_comb begin
        sum       = {1'b0, base} + {1'b0, step};
        diff      = {1'b0, base} - {1'b0, step};
        sum_wrap  = sum - N_EXT;
        diff_wrap = diff + N_EXT;
        if (sub) begin
            // Top bit of diff is the borrow since both operands are below 2**gp_aw.
            result = diff[gp_aw] ? diff_wrap[gp_aw-1:0] : diff[gp_aw-1:0];
        end else begin
            result = (sum >= N_EXT) ? sum_wrap[gp_aw-1:0] : sum[gp_aw-1:0];
        end
    end
endmodule

// File: rtl/filt_mac_seq.sv
// Time-multiplexed MAC FIR sequencer: sample handshake, circular delay-line pointers, tap stepping.
// Optional FILT_MAC_SEQ_DROP_CNT_EN enables the saturating dropped-sample counter.
module filt_mac_seq
    import filt_mac_pkg::*;
#(
    parameter int gp_coeff_length = 17,
    parameter int gp_symm         = 1,
    parameter int gp_mac_latency  = 2,
    parameter int gp_cnt_width    = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_an,
    filt_mac_seq_if.master bus
);
    localparam int unsigned N  = gp_coeff_length;
    localparam int unsigned AW = addr_width(N);
    localparam int unsigned M  = (gp_symm != 0) ? div2(N) : N;
    localparam int unsigned L  = gp_mac_latency;
    localparam int unsigned DW = $clog2(L + 2);

    localparam logic [AW-1:0] K_LAST   = AW'(M - 1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [DW-1:0] D_LAST   = DW'((L > 0) ? L - 1 : 0);
    localparam logic [DW-1:0] D_ONE    = DW'(1);
    localparam logic          MID_EN   = (gp_symm != 0) && (N % 2 == 1);
    localparam logic          SYMM     = (gp_symm != 0);

    seq_state_t    state, state_nxt;
    logic [AW-1:0] wptr, k, rd_a, rd_b;
    logic [AW-1:0] rd_a_dec, b_base, b_inc;
    logic [DW-1:0] dcnt;
    logic          ready, accept, in_mac;

    // Port b's adder doubles as the write-pointer increment while idle.
    assign b_base = (state == MAC) ? rd_b : wptr;

    filt_mac_seq_addr #(.gp_coeff_length(N), .gp_aw(AW)) u_addr_a (
        .base(rd_a), .step(ADDR_ONE), .sub(1'b1), .result(rd_a_dec)
    );

    filt_mac_seq_addr #(.gp_coeff_length(N), .gp_aw(AW)) u_addr_b (
        .base(b_base), .step(ADDR_ONE), .sub(1'b0), .result(b_inc)
    );

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        ready     = (state == IDLE) & bus.i_ena & i_rst_an;
        accept    = ready & bus.i_valid;
        in_mac    = (state == MAC);
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = MAC;
            MAC:     if (bus.i_ena && k == K_LAST) state_nxt = (L == 0) ? DONE : DRAIN;
            DRAIN:   if (bus.i_ena && dcnt == D_LAST) state_nxt = DONE;
            DONE:    if (bus.i_ena) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        bus.o_ready      = ready;
        bus.o_wr_en      = accept;
        bus.o_wr_addr    = wptr;
        bus.o_acc_en     = in_mac & bus.i_ena;
        bus.o_acc_clr    = in_mac & bus.i_ena & (k == '0);
        bus.o_coeff_addr = in_mac ? k : '0;
        bus.o_rd_addr_a  = in_mac ? rd_a : '0;
        bus.o_rd_addr_b  = (in_mac && SYMM) ? rd_b : '0;
        bus.o_mid        = in_mac & MID_EN & (k == K_LAST);
        bus.o_done       = (state == DONE) & bus.i_ena;
    end

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            wptr <= '0;
            k    <= '0;
            rd_a <= '0;
            rd_b <= '0;
            dcnt <= '0;
        end else if (bus.i_ena) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wptr <= b_inc;
                        rd_a <= wptr;
                        rd_b <= b_inc;
                        k    <= '0;
                    end
                end
                MAC: begin
                    if (k == K_LAST) dcnt <= '0;
                    else             k    <= k + ADDR_ONE;
                    rd_a <= rd_a_dec;
                    rd_b <= b_inc;
                end
                DRAIN:   dcnt <= dcnt + D_ONE;
                default: ;
            endcase
        end
    end

`ifdef FILT_MAC_SEQ_DROP_CNT_EN
    logic [gp_cnt_width-1:0] drop_cnt;

    always_ff @(posedge i_clk or negedge i_rst_an) begin
        if (!i_rst_an) begin
            drop_cnt <= '0;
        end else if (bus.i_valid && !ready && bus.i_ena && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign bus.o_drop_cnt = drop_cnt;
`else
    assign bus.o_drop_cnt = '0;
`endif

endmodule
